// File: rtl/milano_pkg.sv
// Shared types and defaults for the milano core.
// The writeback arbiter uses wb_src_e to report which producer owns the write port.
package milano_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  localparam int WB_STARVE_MAX_DEF = 4;

endpackage

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU and the LSU.
// The LSU wins contention until the ALU has been denied STARVE_MAX times in a row.
import milano_pkg::*;

module wb_port_arbiter #(
  parameter int STARVE_MAX = WB_STARVE_MAX_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        reg_we_o,
  output logic [4:0]  wr_addr_o,
  output logic [31:0] rd_wdata_o,
  output wb_src_e     wb_src_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_nxt;

  always_comb begin
    alu_ready_o    = 1'b0;
    lsu_ready_o    = 1'b0;
    starve_cnt_nxt = '0;
    if (!flush_i) begin
      if (alu_valid_i && lsu_valid_i) begin
        alu_ready_o = (starve_cnt == STARVE_LIM);
        lsu_ready_o = (starve_cnt != STARVE_LIM);
      end else begin
        alu_ready_o = alu_valid_i;
        lsu_ready_o = lsu_valid_i;
      end
    end
    // The ALU only accumulates starvation while it is actually waiting.
    if (!flush_i && alu_valid_i && !alu_ready_o) begin
      starve_cnt_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  // Writes to x0 are accepted but suppressed; address and data then hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
      reg_we_o   <= 1'b0;
      wr_addr_o  <= '0;
      rd_wdata_o <= '0;
      wb_src_o   <= WB_NONE;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (alu_ready_o) begin
        reg_we_o <= (alu_addr_i != 5'd0);
        wb_src_o <= WB_ALU;
        if (alu_addr_i != 5'd0) begin
          wr_addr_o  <= alu_addr_i;
          rd_wdata_o <= alu_data_i;
        end
      end else if (lsu_ready_o) begin
        reg_we_o <= (lsu_addr_i != 5'd0);
        wb_src_o <= WB_LSU;
        if (lsu_addr_i != 5'd0) begin
          wr_addr_o  <= lsu_addr_i;
          rd_wdata_o <= lsu_data_i;
        end
      end else begin
        reg_we_o <= 1'b0;
        wb_src_o <= WB_NONE;
      end
    end
  end

endmodule
